ddr_adc_record_unpacker: RTL and testbench
==========================================

# ddr_adc_record_unpacker

Parametrised successor of the DDR ADC stream parser. It unpacks a DDR read-back stream of DATA_WD-bit beats carrying tightly packed records. Each record is one HEAD_WD header plus one DATA_WD ADC word. It emits each header and its data word together as one record on a backpressured output, and adds frame-sync hunting, error flagging, a raw bypass mode and status counters. It sits between the DDR read FIFO and the ADC channel distributor.

## Interface
- DATA_WD, 512, beat and ADC word width; must be a multiple of HEAD_WD.
- HEAD_WD, 64, header width. R = DATA_WD/HEAD_WD records per frame, with R ≥ 2.
- SYNC_EN, 1, enables header sync check and frame hunting.
- SYNC_WD, 16, sync field width, located at header[HEAD_WD-1 -: SYNC_WD].
- SYNC_PAT, 16'h55AA, expected sync field value.
- clk  in  1  single clock domain.
- rst  in  1  asynchronous, active-high reset.
- cfg_rst  in  1  synchronous soft clear; also the load window for cfg_bypass.
- cfg_bypass  in  1  raw mode select; latched only while cfg_rst=1.
- s_axis_tdata  in  DATA_WD  input beat.
- s_axis_tvalid  in  1  input beat valid.
- s_axis_tready  out  1  input ready.
- m_head_data  out  HEAD_WD  record header.
- m_adc_data  out  DATA_WD  record ADC word.
- m_tvalid  out  1  record valid.
- m_tready  in  1  downstream ready.
- m_tlast  out  1  last record of the frame (record R-1).
- m_head_err  out  1  record header failed the sync check.
- frame_cnt  out  32  completed frames; wraps.
- sync_err_cnt  out  16  flagged headers; saturates at 16'hFFFF.
- drop_cnt  out  16  beats discarded while hunting; saturates.

## Operation
- A frame is R+1 beats. Beat counter cnt runs 0..R.
- Let o_j = j·HEAD_WD.
- Record j (0..R-1): header = beat_j[o_j+HEAD_WD-1:o_j].
- Record j data = {beat_{j+1}[o_{j+1}-1:0], beat_j[DATA_WD-1:o_j+HEAD_WD]}.
- Record R-1 data = beat_R entirely.
- Beat accept: s_axis_tvalid & s_axis_tready.
- s_axis_tready = ~cfg_rst & (~m_tvalid | m_tready). Forced 0 while rst=1.
- Each accepted beat updates a previous-beat register and a header-hold register (slot cnt).
- Packed mode, accept at cnt=0:
  - SYNC_EN=1 and slot-0 sync field ≠ SYNC_PAT: beat discarded, cnt stays 0, drop_cnt+1 (hunt).
  - Otherwise cnt→1. No output.
- Packed mode, accept at cnt=k (1..R):
  - Output register loads record k-1; m_tvalid=1.
  - m_tlast = (k==R).
  - cnt→k+1, or 0 when k==R, in which case frame_cnt+1.
- Sync check on headers 1..R-1 (SYNC_EN=1): a mismatch does not realign.
  - Record is still emitted with m_head_err=1; sync_err_cnt+1.
  - m_head_err is evaluated per record, including record 0.
- Bypass mode:
  - Each accepted beat is emitted as m_adc_data = beat, m_head_data = 0, m_tlast = 1, m_head_err = 0.
  - cnt is held at 0; no counters change.
- Output register hold: while m_tvalid & ~m_tready, all m_* outputs are held stable.
- cfg_rst=1 (synchronous, priority over all traffic):
  - cnt=0, m_tvalid=0, all three counters=0, hold registers cleared.
  - Mode register ← cfg_bypass.
- Arithmetic: counters are unsigned. Saturating counters never wrap.

## Timing
- Reset values: m_tvalid, m_tlast and m_head_err are 0; all data outputs are 0; all counters are 0; mode is packed; cnt is 0.
- Latency: the record from beat k becomes valid the cycle after beat k is accepted (1 cycle).
- Throughput: one record per cycle when m_tready=1. Frame efficiency is R records per R+1 beats.
- Simultaneous output drain and new accept in the same cycle: the output register reloads with no bubble.
- Reset or cfg_rst mid-frame: the partial frame is lost, and the next accepted beat is treated as beat 0.
- Mode change outside the cfg_rst window: ignored.

## Test plan
- Default parameters. 2 frames with headers {16'h55AA, idx} and data incrementing per 64-bit lane, m_tready=1.
  - Expect 16 records, each with header matched to its data.
  - m_tlast on records 8 and 16; frame_cnt=2; no errors.
- Random s_axis_tvalid and m_tready at 50% each.
  - Record stream is identical to the previous case.
  - m_* stable whenever m_tvalid=1 and m_tready=0; no beat lost.
- Prepend 3 beats whose slot-0 sync is 16'h0000, then a valid frame.
  - drop_cnt=3; frame locks and all 8 records are correct.
- Corrupt the header sync in slot 5 of one frame.
  - Record 5 has m_head_err=1; sync_err_cnt=1; the following frame is aligned.
- Assert cfg_rst after beat 4 with cfg_bypass=1, then send 4 beats.
  - 4 records equal to the raw beats, each with m_tlast=1 and m_head_data=0; counters read 0.
- Assert rst mid-frame with m_tvalid=1.
  - All outputs immediately 0; a new frame parses correctly from its first beat.

Source files
------------

// File: rtl/ddr_adc_record_unpacker.sv
`default_nettype none
// ============================================================================
// Module   : ddr_adc_record_unpacker
// Purpose  : Unpacks a DDR read-back stream of DATA_WD-bit beats carrying
//            tightly packed {header, ADC word} records. A frame of R+1 beats
//            (R = DATA_WD/HEAD_WD) yields R records on a backpressured output.
//            Adds frame-sync hunting on slot 0, per-record header sync
//            flagging, a raw bypass mode and status counters.
// Ports    : clk, rst (async, active-high)
//            cfg_rst      - synchronous soft clear, load window for cfg_bypass
//            cfg_bypass   - raw mode select (latched only while cfg_rst=1)
//            s_axis_*     - input beat stream (tdata/tvalid/tready)
//            m_head_data  - record header     m_adc_data - record ADC word
//            m_tvalid/m_tready/m_tlast/m_head_err - record handshake + flags
//            frame_cnt, sync_err_cnt, drop_cnt - status counters
// Revision : 1.0 - initial release
// ============================================================================
module ddr_adc_record_unpacker #(
  parameter int                 DATA_WD  = 512,
  parameter int                 HEAD_WD  = 64,
  parameter bit                 SYNC_EN  = 1'b1,
  parameter int                 SYNC_WD  = 16,
  parameter logic [SYNC_WD-1:0] SYNC_PAT = 16'h55AA
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               cfg_rst,
  input  logic               cfg_bypass,
  input  logic [DATA_WD-1:0] s_axis_tdata,
  input  logic               s_axis_tvalid,
  output logic               s_axis_tready,
  output logic [HEAD_WD-1:0] m_head_data,
  output logic [DATA_WD-1:0] m_adc_data,
  output logic               m_tvalid,
  input  logic               m_tready,
  output logic               m_tlast,
  output logic               m_head_err,
  output logic [31:0]        frame_cnt,
  output logic [15:0]        sync_err_cnt,
  output logic [15:0]        drop_cnt
);

  localparam int R     = DATA_WD / HEAD_WD;
  localparam int CNT_W = $clog2(R + 1);

  // --------------------------------------------------------------------------
  // State
  // --------------------------------------------------------------------------
  logic [CNT_W-1:0]   cnt_q,      cnt_d;
  logic               bypass_q,   bypass_d;
  logic [DATA_WD-1:0] prev_q,     prev_d;      // previous accepted beat
  logic [HEAD_WD-1:0] head_q,     head_d;      // header of record in flight
  logic               herr_q,     herr_d;      // its sync-check result
  logic               ovalid_q,   ovalid_d;
  logic [HEAD_WD-1:0] ohead_q,    ohead_d;
  logic [DATA_WD-1:0] odata_q,    odata_d;
  logic               olast_q,    olast_d;
  logic               oerr_q,     oerr_d;
  logic [31:0]        frame_q,    frame_d;
  logic [15:0]        serr_q,     serr_d;
  logic [15:0]        drop_q,     drop_d;

  // --------------------------------------------------------------------------
  // Combinational helpers
  // --------------------------------------------------------------------------
  logic               w_accept;
  logic [HEAD_WD-1:0] w_hdr;        // header in slot cnt of the incoming beat
  logic               w_hdr_bad;
  logic [DATA_WD-1:0] w_rec [1:R];  // record k-1 data when beat k arrives
  logic [DATA_WD-1:0] w_data;

  assign s_axis_tready = ~rst & ~cfg_rst & (~ovalid_q | m_tready);
  assign w_accept      = s_axis_tvalid & s_axis_tready;

  always_comb begin
    w_hdr = '0;
    for (int k = 0; k < R; k++) begin
      if (cnt_q == CNT_W'(k)) w_hdr = s_axis_tdata[k*HEAD_WD +: HEAD_WD];
    end
  end

  assign w_hdr_bad = SYNC_EN && (w_hdr[HEAD_WD-1 -: SYNC_WD] != SYNC_PAT);

  // Record k-1 data: tail of the previous beat above its header slot, then
  // the bottom k*HEAD_WD bits of the current beat. The last record of a frame
  // occupies the whole final beat.
  generate
    for (genvar k = 1; k < R; k++) begin : g_rec
      assign w_rec[k] = {s_axis_tdata[k*HEAD_WD-1:0], prev_q[DATA_WD-1:k*HEAD_WD]};
    end
  endgenerate
  assign w_rec[R] = s_axis_tdata;

  always_comb begin
    w_data = '0;
    for (int k = 1; k <= R; k++) begin
      if (cnt_q == CNT_W'(k)) w_data = w_rec[k];
    end
  end

  // --------------------------------------------------------------------------
  // Next-state logic
  // --------------------------------------------------------------------------
  always_comb begin
    cnt_d    = cnt_q;
    bypass_d = bypass_q;
    prev_d   = prev_q;
    head_d   = head_q;
    herr_d   = herr_q;
    ovalid_d = ovalid_q;
    ohead_d  = ohead_q;
    odata_d  = odata_q;
    olast_d  = olast_q;
    oerr_d   = oerr_q;
    frame_d  = frame_q;
    serr_d   = serr_q;
    drop_d   = drop_q;

    if (cfg_rst) begin
      cnt_d    = '0;
      bypass_d = cfg_bypass;
      prev_d   = '0;
      head_d   = '0;
      herr_d   = 1'b0;
      ovalid_d = 1'b0;
      ohead_d  = '0;
      odata_d  = '0;
      olast_d  = 1'b0;
      oerr_d   = 1'b0;
      frame_d  = '0;
      serr_d   = '0;
      drop_d   = '0;
    end else begin
      // Drain first; a same-cycle load below overrides it (no bubble).
      if (ovalid_q && m_tready) ovalid_d = 1'b0;

      if (w_accept) begin
        prev_d = s_axis_tdata;
        if (bypass_q) begin
          ovalid_d = 1'b1;
          ohead_d  = '0;
          odata_d  = s_axis_tdata;
          olast_d  = 1'b1;
          oerr_d   = 1'b0;
        end else if (cnt_q == '0) begin
          // Frame start: a bad slot-0 sync means we are not aligned; hunt.
          if (w_hdr_bad) begin
            if (drop_q != 16'hFFFF) drop_d = drop_q + 16'd1;
          end else begin
            cnt_d  = CNT_W'(1);
            head_d = w_hdr;
            herr_d = w_hdr_bad;
          end
        end else begin
          ovalid_d = 1'b1;
          ohead_d  = head_q;
          odata_d  = w_data;
          olast_d  = (cnt_q == CNT_W'(R));
          oerr_d   = herr_q;
          if (herr_q && (serr_q != 16'hFFFF)) serr_d = serr_q + 16'd1;
          if (cnt_q == CNT_W'(R)) begin
            cnt_d   = '0;
            frame_d = frame_q + 32'd1;
          end else begin
            // Mid-frame sync errors are flagged only; alignment is kept.
            cnt_d  = cnt_q + CNT_W'(1);
            head_d = w_hdr;
            herr_d = w_hdr_bad;
          end
        end
      end
    end
  end

  // --------------------------------------------------------------------------
  // State registers
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q    <= '0;
      bypass_q <= 1'b0;
      prev_q   <= '0;
      head_q   <= '0;
      herr_q   <= 1'b0;
      ovalid_q <= 1'b0;
      ohead_q  <= '0;
      odata_q  <= '0;
      olast_q  <= 1'b0;
      oerr_q   <= 1'b0;
      frame_q  <= '0;
      serr_q   <= '0;
      drop_q   <= '0;
    end else begin
      cnt_q    <= cnt_d;
      bypass_q <= bypass_d;
      prev_q   <= prev_d;
      head_q   <= head_d;
      herr_q   <= herr_d;
      ovalid_q <= ovalid_d;
      ohead_q  <= ohead_d;
      odata_q  <= odata_d;
      olast_q  <= olast_d;
      oerr_q   <= oerr_d;
      frame_q  <= frame_d;
      serr_q   <= serr_d;
      drop_q   <= drop_d;
    end
  end

  assign m_tvalid     = ovalid_q;
  assign m_head_data  = ohead_q;
  assign m_adc_data   = odata_q;
  assign m_tlast      = olast_q;
  assign m_head_err   = oerr_q;
  assign frame_cnt    = frame_q;
  assign sync_err_cnt = serr_q;
  assign drop_cnt     = drop_q;

endmodule
`default_nettype wire

// File: tb/tb_ddr_adc_record_unpacker.sv
`default_nettype none
// ============================================================================
// Module   : tb_ddr_adc_record_unpacker
// Purpose  : Self-checking bench. Frames are built as one contiguous bit
//            string of packed {header, data} records and cut into beats; the
//            expected record list comes straight from that construction.
// Revision : 1.0 - initial release
// ============================================================================
module tb_ddr_adc_record_unpacker;

  localparam int DW = 512;
  localparam int HW = 64;
  localparam int R  = DW / HW;
  localparam int RW = HW + DW;
  localparam logic [15:0] PAT = 16'h55AA;

  typedef struct packed {
    logic [HW-1:0] h;
    logic [DW-1:0] d;
    logic          last;
    logic          err;
  } rec_t;

  logic          clk = 1'b0;
  logic          rst, cfg_rst, cfg_bypass;
  logic [DW-1:0] s_axis_tdata;
  logic          s_axis_tvalid, s_axis_tready;
  logic [HW-1:0] m_head_data;
  logic [DW-1:0] m_adc_data;
  logic          m_tvalid, m_tready, m_tlast, m_head_err;
  logic [31:0]   frame_cnt;
  logic [15:0]   sync_err_cnt, drop_cnt;

  ddr_adc_record_unpacker dut (
    .clk(clk), .rst(rst), .cfg_rst(cfg_rst), .cfg_bypass(cfg_bypass),
    .s_axis_tdata(s_axis_tdata), .s_axis_tvalid(s_axis_tvalid),
    .s_axis_tready(s_axis_tready), .m_head_data(m_head_data),
    .m_adc_data(m_adc_data), .m_tvalid(m_tvalid), .m_tready(m_tready),
    .m_tlast(m_tlast), .m_head_err(m_head_err), .frame_cnt(frame_cnt),
    .sync_err_cnt(sync_err_cnt), .drop_cnt(drop_cnt)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int passes = 0;
  int rdy_mode = 0;   // 0: always ready, 1: random 50%, 2: never ready
  bit stab_en = 0;
  int stab_viol = 0;

  logic [DW-1:0] beat_q[$];
  rec_t          exp_q[$];
  rec_t          got_q[$];

  // Downstream ready driver
  initial begin
    m_tready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      m_tready = (rdy_mode == 0) ? 1'b1 : (rdy_mode == 1) ? 1'($urandom % 2) : 1'b0;
    end
  end

  // Output monitor: collects transferred records and counts hold violations
  initial begin
    rec_t cur, prv;
    bit   hold;
    hold = 0;
    prv  = '0;
    forever begin
      @(negedge clk);
      cur = '{h: m_head_data, d: m_adc_data, last: m_tlast, err: m_head_err};
      if (stab_en && hold && (cur !== prv)) stab_viol++;
      if (m_tvalid && m_tready) got_q.push_back(cur);
      hold = m_tvalid && !m_tready;
      prv  = cur;
    end
  end

  function automatic logic [DW-1:0] rnd_beat();
    logic [DW-1:0] v;
    for (int i = 0; i < DW/32; i++) v[i*32 +: 32] = $urandom;
    return v;
  endfunction

  // Builds one frame as a packed record bit string; bad_slot gets a wrong sync
  task automatic make_frame(input int bad_slot, input bit push_exp);
    logic [R*RW-1:0] fs;
    logic [HW-1:0]   h;
    logic [DW-1:0]   d;
    logic [DW-1:0]   t;
    for (int j = 0; j < R; j++) begin
      t = rnd_beat();
      h = {(j == bad_slot) ? (PAT ^ 16'h0100) : PAT, t[HW-17:0]};
      d = rnd_beat();
      fs[j*RW +: HW]      = h;
      fs[j*RW + HW +: DW] = d;
      if (push_exp) exp_q.push_back('{h: h, d: d, last: (j == R-1), err: (j == bad_slot)});
    end
    for (int b = 0; b <= R; b++) beat_q.push_back(fs[b*DW +: DW]);
  endtask

  // Sends up to n beats from beat_q; vprob = percent chance of valid per cycle
  task automatic send_beats(input int n, input int vprob);
    int sent = 0;
    int budget = 0;
    bit acc;
    while (beat_q.size() > 0 && sent < n && budget < 20000) begin
      budget++;
      if ($urandom_range(99) >= vprob) begin
        s_axis_tvalid = 1'b0;
        @(posedge clk);
        #1;
      end else begin
        s_axis_tvalid = 1'b1;
        s_axis_tdata  = beat_q[0];
        @(negedge clk);
        acc = s_axis_tready;
        @(posedge clk);
        #1;
        if (acc) begin
          void'(beat_q.pop_front());
          sent++;
        end
      end
    end
    s_axis_tvalid = 1'b0;
  endtask

  task automatic wait_drain();
    int c = 0;
    while (got_q.size() < exp_q.size() && c < 3000) begin
      @(posedge clk);
      c++;
    end
    repeat (3) @(posedge clk);
    #1;
  endtask

  task automatic soft_clear(input logic byp);
    @(posedge clk);
    #1;
    cfg_rst = 1'b1;
    cfg_bypass = byp;
    @(posedge clk);
    #1;
    cfg_rst = 1'b0;
    cfg_bypass = 1'b0;
    got_q.delete();
    exp_q.delete();
    beat_q.delete();
  endtask

  task automatic test_reset();
    checks++; if (m_tvalid !== 1'b0) $display("FAIL reset_tvalid got %b exp 0", m_tvalid); else passes++;
    checks++; if (m_tlast !== 1'b0) $display("FAIL reset_tlast got %b exp 0", m_tlast); else passes++;
    checks++; if (m_head_err !== 1'b0) $display("FAIL reset_head_err got %b exp 0", m_head_err); else passes++;
    checks++; if (m_head_data !== '0 || m_adc_data !== '0) $display("FAIL reset_data got %h/%h exp 0", m_head_data, m_adc_data); else passes++;
    checks++; if (frame_cnt !== 0 || sync_err_cnt !== 0 || drop_cnt !== 0)
      $display("FAIL reset_counters got %0d/%0d/%0d exp 0/0/0", frame_cnt, sync_err_cnt, drop_cnt); else passes++;
    checks++; if (s_axis_tready !== 1'b1) $display("FAIL reset_tready got %b exp 1", s_axis_tready); else passes++;
  endtask

  task automatic test_packed();
    soft_clear(1'b0);
    rdy_mode = 0;
    make_frame(-1, 1);
    make_frame(-1, 1);
    send_beats(1000, 100);
    wait_drain();
    checks++; if (got_q.size() != exp_q.size()) $display("FAIL packed_count got %0d exp %0d", got_q.size(), exp_q.size()); else passes++;
    for (int i = 0; i < exp_q.size(); i++) begin
      checks++;
      if (i >= got_q.size() || got_q[i] !== exp_q[i])
        $display("FAIL packed_rec%0d got %h exp %h", i, (i < got_q.size()) ? got_q[i] : '0, exp_q[i]);
      else passes++;
    end
    checks++; if (frame_cnt !== 32'd2) $display("FAIL packed_frame_cnt got %0d exp 2", frame_cnt); else passes++;
    checks++; if (sync_err_cnt !== 0 || drop_cnt !== 0) $display("FAIL packed_errs got %0d/%0d exp 0/0", sync_err_cnt, drop_cnt); else passes++;
  endtask

  task automatic test_random_handshake();
    soft_clear(1'b0);
    rdy_mode = 1;
    stab_viol = 0;
    stab_en = 1;
    make_frame(-1, 1);
    make_frame(-1, 1);
    send_beats(1000, 50);
    rdy_mode = 0;
    wait_drain();
    stab_en = 0;
    checks++; if (got_q.size() != exp_q.size()) $display("FAIL random_count got %0d exp %0d", got_q.size(), exp_q.size()); else passes++;
    for (int i = 0; i < exp_q.size(); i++) begin
      checks++;
      if (i >= got_q.size() || got_q[i] !== exp_q[i])
        $display("FAIL random_rec%0d got %h exp %h", i, (i < got_q.size()) ? got_q[i] : '0, exp_q[i]);
      else passes++;
    end
    checks++; if (stab_viol != 0) $display("FAIL random_hold_stable got %0d changes exp 0", stab_viol); else passes++;
    checks++; if (frame_cnt !== 32'd2) $display("FAIL random_frame_cnt got %0d exp 2", frame_cnt); else passes++;
  endtask

  task automatic test_hunt();
    logic [DW-1:0] b;
    soft_clear(1'b0);
    rdy_mode = 0;
    for (int i = 0; i < 3; i++) begin
      b = rnd_beat();
      b[HW-1 -: 16] = 16'h0000;
      beat_q.push_back(b);
    end
    make_frame(-1, 1);
    send_beats(1000, 100);
    wait_drain();
    checks++; if (drop_cnt !== 16'd3) $display("FAIL hunt_drop_cnt got %0d exp 3", drop_cnt); else passes++;
    checks++; if (got_q.size() != exp_q.size()) $display("FAIL hunt_count got %0d exp %0d", got_q.size(), exp_q.size()); else passes++;
    for (int i = 0; i < exp_q.size(); i++) begin
      checks++;
      if (i >= got_q.size() || got_q[i] !== exp_q[i])
        $display("FAIL hunt_rec%0d got %h exp %h", i, (i < got_q.size()) ? got_q[i] : '0, exp_q[i]);
      else passes++;
    end
    checks++; if (frame_cnt !== 32'd1) $display("FAIL hunt_frame_cnt got %0d exp 1", frame_cnt); else passes++;
  endtask

  task automatic test_sync_err();
    soft_clear(1'b0);
    rdy_mode = 0;
    make_frame(5, 1);
    make_frame(-1, 1);
    send_beats(1000, 100);
    wait_drain();
    checks++; if (got_q.size() != exp_q.size()) $display("FAIL syncerr_count got %0d exp %0d", got_q.size(), exp_q.size()); else passes++;
    for (int i = 0; i < exp_q.size(); i++) begin
      checks++;
      if (i >= got_q.size() || got_q[i] !== exp_q[i])
        $display("FAIL syncerr_rec%0d got %h exp %h", i, (i < got_q.size()) ? got_q[i] : '0, exp_q[i]);
      else passes++;
    end
    checks++; if (sync_err_cnt !== 16'd1) $display("FAIL syncerr_cnt got %0d exp 1", sync_err_cnt); else passes++;
    checks++; if (frame_cnt !== 32'd2 || drop_cnt !== 0) $display("FAIL syncerr_frames got %0d/%0d exp 2/0", frame_cnt, drop_cnt); else passes++;
  endtask

  task automatic test_bypass();
    logic [DW-1:0] b;
    soft_clear(1'b0);
    rdy_mode = 0;
    make_frame(-1, 1);
    while (exp_q.size() > 3) void'(exp_q.pop_back());
    send_beats(4, 100);
    wait_drain();
    checks++; if (got_q.size() != 3) $display("FAIL bypass_pre_count got %0d exp 3", got_q.size()); else passes++;
    checks++; if (got_q.size() < 3 || got_q[2] !== exp_q[2]) $display("FAIL bypass_pre_rec2 got %0d recs exp match", got_q.size()); else passes++;
    soft_clear(1'b1);
    for (int i = 0; i < 4; i++) begin
      b = rnd_beat();
      beat_q.push_back(b);
      exp_q.push_back('{h: '0, d: b, last: 1'b1, err: 1'b0});
    end
    send_beats(1000, 100);
    wait_drain();
    checks++; if (got_q.size() != 4) $display("FAIL bypass_count got %0d exp 4", got_q.size()); else passes++;
    for (int i = 0; i < exp_q.size(); i++) begin
      checks++;
      if (i >= got_q.size() || got_q[i] !== exp_q[i])
        $display("FAIL bypass_rec%0d got %h exp %h", i, (i < got_q.size()) ? got_q[i] : '0, exp_q[i]);
      else passes++;
    end
    checks++; if (frame_cnt !== 0 || sync_err_cnt !== 0 || drop_cnt !== 0)
      $display("FAIL bypass_counters got %0d/%0d/%0d exp 0/0/0", frame_cnt, sync_err_cnt, drop_cnt); else passes++;
    soft_clear(1'b0);
  endtask

  task automatic test_reset_mid();
    soft_clear(1'b0);
    rdy_mode = 2;
    m_tready = 1'b0;
    make_frame(-1, 0);
    send_beats(2, 100);
    beat_q.delete();
    checks++; if (m_tvalid !== 1'b1) $display("FAIL rstmid_pre_tvalid got %b exp 1", m_tvalid); else passes++;
    #2;
    rst = 1'b1;
    #1;
    checks++; if (m_tvalid !== 1'b0 || m_tlast !== 1'b0 || m_head_err !== 1'b0)
      $display("FAIL rstmid_flags got %b%b%b exp 000", m_tvalid, m_tlast, m_head_err); else passes++;
    checks++; if (m_head_data !== '0 || m_adc_data !== '0) $display("FAIL rstmid_data got %h/%h exp 0", m_head_data, m_adc_data); else passes++;
    checks++; if (s_axis_tready !== 1'b0) $display("FAIL rstmid_tready got %b exp 0", s_axis_tready); else passes++;
    @(posedge clk);
    #1;
    rst = 1'b0;
    rdy_mode = 0;
    m_tready = 1'b1;
    got_q.delete();
    make_frame(-1, 1);
    send_beats(1000, 100);
    wait_drain();
    checks++; if (got_q.size() != exp_q.size()) $display("FAIL rstmid_count got %0d exp %0d", got_q.size(), exp_q.size()); else passes++;
    for (int i = 0; i < exp_q.size(); i++) begin
      checks++;
      if (i >= got_q.size() || got_q[i] !== exp_q[i])
        $display("FAIL rstmid_rec%0d got %h exp %h", i, (i < got_q.size()) ? got_q[i] : '0, exp_q[i]);
      else passes++;
    end
    checks++; if (frame_cnt !== 32'd1) $display("FAIL rstmid_frame_cnt got %0d exp 1", frame_cnt); else passes++;
  endtask

  initial begin
    rst = 1'b1;
    cfg_rst = 1'b0;
    cfg_bypass = 1'b0;
    s_axis_tvalid = 1'b0;
    s_axis_tdata = '0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    #1;
    test_reset();
    test_packed();
    test_random_handshake();
    test_hunt();
    test_sync_err();
    test_bypass();
    test_reset_mid();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
`default_nettype wire
